// File: rtl/cs_vector_loader_if.sv
// Signal bundle between the vector loader and its host, embedding memory
// and cosine-similarity wrapper. master = loader side, slave = environment.
interface cs_vector_loader_if #(
    parameter int D_Len = 32,
    parameter int AW    = 10
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [AW-1:0]    base_a1;
    logic [AW-1:0]    base_a2;
    logic             mem_rd_en;
    logic [AW-1:0]    mem_addr;
    logic [D_Len-1:0] mem_rdata;
    logic             cs_we;
    logic             cs_vct_sel;
    logic [D_Len-1:0] cs_data;
    logic             cs_start;
    logic             cs_done;
    logic [D_Len-1:0] cs_result;
    logic             cs_error;
    logic             res_valid;
    logic             res_ready;
    logic [D_Len-1:0] res_data;
    logic [1:0]       res_status;
    logic             busy;

    modport master (
        input  cmd_valid, base_a1, base_a2, mem_rdata, cs_done, cs_result, cs_error, res_ready,
        output cmd_ready, mem_rd_en, mem_addr, cs_we, cs_vct_sel, cs_data, cs_start,
               res_valid, res_data, res_status, busy
    );

    modport slave (
        output cmd_valid, base_a1, base_a2, mem_rdata, cs_done, cs_result, cs_error, res_ready,
        input  cmd_ready, mem_rd_en, mem_addr, cs_we, cs_vct_sel, cs_data, cs_start,
               res_valid, res_data, res_status, busy
    );
endinterface

// File: rtl/cs_vector_loader.sv
// Streams two embedding vectors from on-chip memory into the similarity wrapper,
// screens words for NaN/Inf, runs the compute with a timeout and returns score + status.
module cs_vector_loader #(
    parameter int D_Len   = 32,
    parameter int Ele_Num = 128,
    parameter int AW      = 10,
    parameter int TIMEOUT = 4096
) (
    input logic                clk,
    input logic                rst_n,
    cs_vector_loader_if.master bus
);
    localparam int STAGES = 2;
    localparam int CW     = $clog2(2*Ele_Num) + 1;
    localparam int TW     = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST_RD = CW'(2*Ele_Num - 1);
    localparam logic [CW-1:0] LAST_V1 = CW'(Ele_Num - 1);
    // Counter is registered: leave WAIT on the edge where it reaches TIMEOUT-1.
    localparam logic [TW-1:0] TMO_CNT = TW'(TIMEOUT - 2);

    localparam logic [1:0] ST_OK     = 2'd0;
    localparam logic [1:0] ST_CS_ERR = 2'd1;
    localparam logic [1:0] ST_BAD_IN = 2'd2;
    localparam logic [1:0] ST_TMO    = 2'd3;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, START, WAIT, ERR, RESP} state_t;

    state_t            state;
    logic [AW-1:0]     base2_q;
    logic [AW-1:0]     addr_q;
    logic [CW-1:0]     rd_cnt;
    logic [TW-1:0]     wait_cnt;
    // [0] read strobe, [1] memory data valid, [2] write strobe to wrapper
    logic [STAGES:0]   vld_pipe;
    logic [STAGES:0]   sel_pipe;
    logic [D_Len-1:0]  wdata_q;
    logic [D_Len-1:0]  res_data_q;
    logic [1:0]        status_q;
    logic              cmd_ready_q;
    logic              start_q;
    logic              res_valid_q;
    logic              bad_word;

    assign bad_word = vld_pipe[1] && (bus.mem_rdata[30:23] == 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            base2_q     <= '0;
            addr_q      <= '0;
            rd_cnt      <= '0;
            wait_cnt    <= '0;
            vld_pipe    <= '0;
            sel_pipe    <= '0;
            wdata_q     <= '0;
            res_data_q  <= '0;
            status_q    <= ST_OK;
            cmd_ready_q <= 1'b1;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            vld_pipe[2:1] <= {vld_pipe[1] & ~bad_word, vld_pipe[0]};
            sel_pipe[2:1] <= sel_pipe[1:0];
            if (vld_pipe[1])
                wdata_q <= bus.mem_rdata;
            start_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        base2_q     <= bus.base_a2;
                        addr_q      <= bus.base_a1;
                        rd_cnt      <= '0;
                        vld_pipe[0] <= 1'b1;
                        sel_pipe[0] <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    if (bad_word) begin
                        vld_pipe <= '0;
                        status_q <= ST_BAD_IN;
                        state    <= ERR;
                    end else if (rd_cnt == LAST_RD) begin
                        vld_pipe[0] <= 1'b0;
                        state       <= DRAIN;
                    end else begin
                        rd_cnt      <= rd_cnt + 1'b1;
                        addr_q      <= (rd_cnt == LAST_V1) ? base2_q : addr_q + 1'b1;
                        sel_pipe[0] <= (rd_cnt >= LAST_V1);
                    end
                end
                DRAIN: begin
                    if (bad_word) begin
                        vld_pipe <= '0;
                        status_q <= ST_BAD_IN;
                        state    <= ERR;
                    end else if (!vld_pipe[1]) begin
                        start_q <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // error beats done when both arrive together
                    if (bus.cs_error) begin
                        status_q <= ST_CS_ERR;
                        state    <= ERR;
                    end else if (bus.cs_done) begin
                        res_data_q  <= bus.cs_result;
                        status_q    <= ST_OK;
                        res_valid_q <= 1'b1;
                        state       <= RESP;
                    end else if (wait_cnt == TMO_CNT) begin
                        status_q <= ST_TMO;
                        state    <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ERR: begin
                    res_data_q  <= '0;
                    res_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.mem_rd_en  = vld_pipe[0];
    assign bus.mem_addr   = addr_q;
    assign bus.cs_we      = vld_pipe[2];
    assign bus.cs_vct_sel = sel_pipe[2];
    assign bus.cs_data    = wdata_q;
    assign bus.cs_start   = start_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_status = status_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_cs_vector_loader.sv
// Directed bench for cs_vector_loader: memory and wrapper models, cycle-stamped
// monitor relative to the command-accept cycle (cycle 0).
module tb_cs_vector_loader;
    localparam int DL = 32;
    localparam int EN = 4;
    localparam int AW = 10;
    localparam int TO = 16;
    localparam logic [DL-1:0] ONE = 32'h3F800000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cs_vector_loader_if #(.D_Len(DL), .AW(AW)) bus ();

    cs_vector_loader #(.D_Len(DL), .Ele_Num(EN), .AW(AW), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    int rel   = 0;
    int wcnt  = 0;
    int wmode = 0;   // 0 done, 1 never answers, 2 done+error together
    bit mon   = 0;

    logic [DL-1:0] mem [0:1023];

    int            rd_c [$];
    logic [AW-1:0] rd_a [$];
    int            we_c [$];
    logic          we_s [$];
    logic [DL-1:0] we_d [$];
    int            st_c [$];
    int            rv_c;
    logic [DL-1:0] rv_d;
    logic [1:0]    rv_s;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

    // monitor + wrapper model: done/error 5 cycles after cs_start
    always @(negedge clk) begin
        if (mon) begin
            rel = cyc - t0;
            if (bus.mem_rd_en) begin rd_c.push_back(rel); rd_a.push_back(bus.mem_addr); end
            if (bus.cs_we) begin
                we_c.push_back(rel); we_s.push_back(bus.cs_vct_sel); we_d.push_back(bus.cs_data);
            end
            if (bus.cs_start) st_c.push_back(rel);
            if (bus.res_valid && rv_c < 0) begin
                rv_c = rel; rv_d = bus.res_data; rv_s = bus.res_status;
            end
        end
        if (bus.cs_start) wcnt = 1;
        else if (wcnt > 0) wcnt++;
        bus.cs_done  = (wcnt == 6) && (wmode != 1);
        bus.cs_error = (wcnt == 6) && (wmode == 2);
    end

    task automatic send(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        @(negedge clk);
        rd_c.delete(); rd_a.delete(); we_c.delete(); we_s.delete(); we_d.delete(); st_c.delete();
        rv_c = -1;
        bus.cmd_valid = 1'b1; bus.base_a1 = a1; bus.base_a2 = a2;
        t0 = cyc; mon = 1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rv(output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.res_valid) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic ack();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic load_ones();
        for (int i = 0; i < 4; i++) begin mem[i] = ONE; mem[8+i] = ONE; end
    endtask

    task automatic test_reset();
        logic [82:0] obs;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        obs = {bus.cmd_ready, bus.mem_rd_en, bus.mem_addr, bus.cs_we, bus.cs_vct_sel, bus.cs_data,
               bus.cs_start, bus.res_valid, bus.res_data, bus.res_status, bus.busy};
        total++;
        if (obs !== {1'b1, 82'd0}) begin
            bad++; $display("FAIL reset_outputs: got %h want %h", obs, {1'b1, 82'd0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.cmd_ready, bus.busy} !== 2'b10) begin
            bad++; $display("FAIL reset_release: ready/busy got %b want 10", {bus.cmd_ready, bus.busy});
        end
    endtask

    task automatic test_basic();
        bit ok;
        load_ones();
        wmode = 0;
        bus.res_ready = 1'b1;   // held high before result exists
        send(10'd0, 10'd8);
        wait_rv(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_wait: res_valid never seen"); end
        @(negedge clk);
        bus.res_ready = 1'b0;
        total++;
        if ({bus.res_valid, bus.cmd_ready} !== 2'b01) begin
            bad++; $display("FAIL basic_return_idle: valid/ready got %b want 01", {bus.res_valid, bus.cmd_ready});
        end
        total++;
        if (rd_c.size() != 8) begin
            bad++; $display("FAIL basic_rd_count: got %0d want 8", rd_c.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (rd_c[i] != i + 1 || rd_a[i] !== AW'(i < 4 ? i : i + 4)) begin
                    bad++; $display("FAIL basic_rd[%0d]: cycle %0d addr %0d want cycle %0d addr %0d",
                                    i, rd_c[i], rd_a[i], i + 1, (i < 4 ? i : i + 4));
                end
            end
        end
        total++;
        if (we_c.size() != 8) begin
            bad++; $display("FAIL basic_we_count: got %0d want 8", we_c.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (we_c[i] != i + 3 || we_s[i] !== (i >= 4) || we_d[i] !== ONE) begin
                    bad++; $display("FAIL basic_we[%0d]: cycle %0d sel %b data %h want cycle %0d sel %b data %h",
                                    i, we_c[i], we_s[i], we_d[i], i + 3, (i >= 4), ONE);
                end
            end
        end
        total++;
        if (st_c.size() != 1 || st_c[0] != 11) begin
            bad++; $display("FAIL basic_start: count %0d first %0d want 1 at 11", st_c.size(),
                            st_c.size() > 0 ? st_c[0] : -1);
        end
        total++;
        if (rv_c != 17 || rv_d !== ONE || rv_s !== 2'd0) begin
            bad++; $display("FAIL basic_result: cycle %0d data %h status %0d want 17 %h 0", rv_c, rv_d, rv_s, ONE);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [AW-1:0] ea [8];
        logic [DL-1:0] ed [8];
        ea = '{10'd1022, 10'd1023, 10'd0, 10'd1, 10'd8, 10'd9, 10'd10, 10'd11};
        ed = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
               32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000};
        for (int i = 0; i < 8; i++) mem[ea[i]] = ed[i];
        wmode = 0;
        send(10'd1022, 10'd8);
        wait_rv(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL wrap_wait: res_valid never seen"); end
        ack();
        total++;
        if (rd_a.size() != 8 || we_d.size() != 8) begin
            bad++; $display("FAIL wrap_count: reads %0d writes %0d want 8 8", rd_a.size(), we_d.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (rd_a[i] !== ea[i] || we_d[i] !== ed[i]) begin
                    bad++; $display("FAIL wrap[%0d]: addr %0d data %h want %0d %h", i, rd_a[i], we_d[i], ea[i], ed[i]);
                end
            end
        end
        total++;
        if (rv_s !== 2'd0 || rv_d !== ONE) begin
            bad++; $display("FAIL wrap_result: status %0d data %h want 0 %h", rv_s, rv_d, ONE);
        end
    endtask

    task automatic test_bad_input();
        bit ok;
        int idx [3];
        logic [DL-1:0] pat [3];
        idx = '{2, 4, 7};
        pat = '{32'h7FC00000, 32'h7F800000, 32'hFF800000};
        wmode = 0;
        for (int k = 0; k < 3; k++) begin
            load_ones();
            mem[idx[k] < 4 ? idx[k] : idx[k] + 4] = pat[k];
            send(10'd0, 10'd8);
            wait_rv(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL bad_in_wait[%0d]: res_valid never seen", k); end
            ack();
            total++;
            if (we_c.size() != idx[k] || st_c.size() != 0) begin
                bad++; $display("FAIL bad_in_strobes[%0d]: we %0d start %0d want %0d 0", k, we_c.size(), st_c.size(), idx[k]);
            end
            total++;
            if (rd_c.size() != (idx[k] + 2 > 8 ? 8 : idx[k] + 2)) begin
                bad++; $display("FAIL bad_in_reads[%0d]: got %0d want %0d", k, rd_c.size(), (idx[k] + 2 > 8 ? 8 : idx[k] + 2));
            end
            total++;
            if (rv_c != idx[k] + 4 || rv_s !== 2'd2 || rv_d !== '0) begin
                bad++; $display("FAIL bad_in_result[%0d]: cycle %0d status %0d data %h want %0d 2 0",
                                k, rv_c, rv_s, rv_d, idx[k] + 4);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        load_ones();
        wmode = 1;
        send(10'd0, 10'd8);
        wait_rv(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL tmo_wait: res_valid never seen"); end
        ack();
        total++;
        if (st_c.size() != 1 || rv_c != st_c[0] + 1 + TO || rv_s !== 2'd3 || rv_d !== '0) begin
            bad++; $display("FAIL tmo_result: start %0d valid %0d status %0d data %h want 11 28 3 0",
                            st_c.size() > 0 ? st_c[0] : -1, rv_c, rv_s, rv_d);
        end
    endtask

    task automatic test_cs_error();
        bit ok;
        load_ones();
        wmode = 2;
        send(10'd0, 10'd8);
        wait_rv(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL cserr_wait: res_valid never seen"); end
        ack();
        total++;
        if (rv_c != 18 || rv_s !== 2'd1 || rv_d !== '0) begin
            bad++; $display("FAIL cserr_result: cycle %0d status %0d data %h want 18 1 0", rv_c, rv_s, rv_d);
        end
    endtask

    task automatic test_hold();
        bit ok;
        load_ones();
        wmode = 0;
        send(10'd0, 10'd8);
        wait_rv(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL hold_wait: res_valid never seen"); end
        bus.cmd_valid = 1'b1;   // must be ignored while busy
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({bus.res_valid, bus.cmd_ready, bus.busy, bus.res_status, bus.res_data} !== {3'b101, 2'd0, ONE}) begin
                bad++; $display("FAIL hold[%0d]: valid %b ready %b busy %b status %0d data %h want 1 0 1 0 %h",
                                i, bus.res_valid, bus.cmd_ready, bus.busy, bus.res_status, bus.res_data, ONE);
            end
        end
        bus.cmd_valid = 1'b0;
        ack();
        total++;
        if ({bus.res_valid, bus.cmd_ready, bus.busy} !== 3'b010) begin
            bad++; $display("FAIL hold_release: valid/ready/busy got %b want 010",
                            {bus.res_valid, bus.cmd_ready, bus.busy});
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [82:0] obs;
        load_ones();
        wmode = 0;
        send(10'd0, 10'd8);
        for (int i = 0; i < 20 && (cyc - t0) < 5; i++) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        obs = {bus.cmd_ready, bus.mem_rd_en, bus.mem_addr, bus.cs_we, bus.cs_vct_sel, bus.cs_data,
               bus.cs_start, bus.res_valid, bus.res_data, bus.res_status, bus.busy};
        total++;
        if (obs !== {1'b1, 82'd0}) begin
            bad++; $display("FAIL midreset_outputs: got %h want %h", obs, {1'b1, 82'd0});
        end
        we_c.delete(); st_c.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (we_c.size() != 0 || st_c.size() != 0 || bus.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL midreset_quiet: we %0d start %0d ready %b want 0 0 1", we_c.size(), st_c.size(), bus.cmd_ready);
        end
        send(10'd0, 10'd8);
        wait_rv(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midreset_wait: res_valid never seen"); end
        ack();
        total++;
        if (we_c.size() != 8 || st_c.size() != 1 || rv_c != 17 || rv_s !== 2'd0 || rv_d !== ONE) begin
            bad++; $display("FAIL midreset_rerun: we %0d start %0d cycle %0d status %0d data %h want 8 1 17 0 %h",
                            we_c.size(), st_c.size(), rv_c, rv_s, rv_d, ONE);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        bus.cmd_valid = 1'b0;
        bus.base_a1   = '0;
        bus.base_a2   = '0;
        bus.res_ready = 1'b0;
        bus.cs_result = ONE;
        test_reset();
        test_basic();
        test_wrap();
        test_bad_input();
        test_timeout();
        test_cs_error();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
